// File: rtl/dac_sample_scheduler_pkg.sv
// rtl/dac_sample_scheduler_pkg.sv - shared constants for the DAC sample path
// Holds the FSM state encoding, the sample width and the default sample
// period, so the scheduler and the DAC transmitter agree on one value.
package dac_sample_scheduler_pkg;

  localparam int SAMPLE_W            = 32;
  localparam int DEFAULT_CLOCK_TICKS = 1000;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] WAIT   = 2'd1;
  localparam logic [1:0] COMMIT = 2'd2;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

endpackage

// File: rtl/dac_sample_scheduler_if.sv
// rtl/dac_sample_scheduler_if.sv - engine/DAC side signals of the sample scheduler
// Ports (slave = scheduler view):
//   i_Mute, i_Odd_Valid/i_Odd_Data, i_Even_Valid/i_Even_Data   : in
//   o_Sample_Start, o_Busy, o_Data_Odd, o_Data_Even,
//   o_Sample_Ready, o_Underrun_Count                           : out
// The master modport is the engine/DAC view of the same bundle.
interface dac_sample_scheduler_if #(
  parameter int UNDERRUN_W = 8
);
  import dac_sample_scheduler_pkg::*;

  logic                  i_Mute;
  logic                  i_Odd_Valid;
  sample_t               i_Odd_Data;
  logic                  i_Even_Valid;
  sample_t               i_Even_Data;
  logic                  o_Sample_Start;
  logic                  o_Busy;
  sample_t               o_Data_Odd;
  sample_t               o_Data_Even;
  logic                  o_Sample_Ready;
  logic [UNDERRUN_W-1:0] o_Underrun_Count;

  modport slave (
    input  i_Mute, i_Odd_Valid, i_Odd_Data, i_Even_Valid, i_Even_Data,
    output o_Sample_Start, o_Busy, o_Data_Odd, o_Data_Even,
           o_Sample_Ready, o_Underrun_Count
  );

  modport master (
    output i_Mute, i_Odd_Valid, i_Odd_Data, i_Even_Valid, i_Even_Data,
    input  o_Sample_Start, o_Busy, o_Data_Odd, o_Data_Even,
           o_Sample_Ready, o_Underrun_Count
  );

endinterface

// File: rtl/sample_rate_ticker.sv
// rtl/sample_rate_ticker.sv - free-running sample period counter
// Ports:
//   i_Clock, i_Reset (sync, active-high)
//   o_Tick : high during the last cycle of each CLOCK_TICKS period
module sample_rate_ticker
  import dac_sample_scheduler_pkg::*;
#(
  parameter int CLOCK_TICKS = DEFAULT_CLOCK_TICKS
) (
  input  logic i_Clock,
  input  logic i_Reset,
  output logic o_Tick
);

  localparam int               CNT_W = $clog2(CLOCK_TICKS);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLOCK_TICKS - 1);

  logic [CNT_W-1:0] Tick_Counter;

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      Tick_Counter <= '0;
    end else if (Tick_Counter == LAST) begin
      Tick_Counter <= '0;
    end else begin
      Tick_Counter <= Tick_Counter + CNT_W'(1);
    end
  end

  assign o_Tick = (Tick_Counter == LAST);

endmodule

// File: rtl/dac_sample_scheduler.sv
// rtl/dac_sample_scheduler.sv - paces harmonic engine requests and commits DAC sample pairs
// Ports:
//   i_Clock, i_Reset (sync, active-high)
//   bus (slave)  : mute, odd/even result strobes and data in;
//                  start request, busy, committed pair, ready pulse and
//                  saturating underrun count out
module dac_sample_scheduler
  import dac_sample_scheduler_pkg::*;
#(
  parameter int CLOCK_TICKS = DEFAULT_CLOCK_TICKS,
  parameter int UNDERRUN_W  = 8
) (
  input  logic                  i_Clock,
  input  logic                  i_Reset,
  dac_sample_scheduler_if.slave bus
);

  localparam logic [UNDERRUN_W-1:0] UNDERRUN_MAX = '1;

  logic       tick;
  logic [1:0] state;
  logic       Tick_Pending;
  logic       Got_Odd;
  logic       Got_Even;
  sample_t    Odd_Hold;
  sample_t    Even_Hold;
  logic       have_odd;
  logic       have_even;
  logic       complete;

  sample_rate_ticker #(.CLOCK_TICKS(CLOCK_TICKS)) u_ticker (
    .i_Clock (i_Clock),
    .i_Reset (i_Reset),
    .o_Tick  (tick)
  );

  // A strobe arriving this cycle counts toward completion immediately, so
  // the pair can commit without waiting an extra cycle for the flag.
  assign have_odd  = Got_Odd  | bus.i_Odd_Valid;
  assign have_even = Got_Even | bus.i_Even_Valid;
  assign complete  = have_odd & have_even;

  assign bus.o_Busy = (state == WAIT);

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state                <= IDLE;
      Tick_Pending         <= 1'b0;
      Got_Odd              <= 1'b0;
      Got_Even             <= 1'b0;
      Odd_Hold             <= '0;
      Even_Hold            <= '0;
      bus.o_Sample_Start   <= 1'b0;
      bus.o_Sample_Ready   <= 1'b0;
      bus.o_Data_Odd       <= '0;
      bus.o_Data_Even      <= '0;
      bus.o_Underrun_Count <= '0;
    end else begin
      bus.o_Sample_Start <= 1'b0;
      bus.o_Sample_Ready <= 1'b0;

      // Remember a tick that could not start a request right away; the
      // branches that do issue a start clear it again below.
      if (tick) begin
        Tick_Pending <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (tick || Tick_Pending) begin
            bus.o_Sample_Start <= 1'b1;
            Tick_Pending       <= 1'b0;
            Got_Odd            <= 1'b0;
            Got_Even           <= 1'b0;
            state              <= WAIT;
          end
        end

        WAIT: begin
          if (bus.i_Odd_Valid) begin
            Odd_Hold <= bus.i_Odd_Data;
          end
          if (bus.i_Even_Valid) begin
            Even_Hold <= bus.i_Even_Data;
          end
          Got_Odd  <= have_odd;
          Got_Even <= have_even;

          if (complete) begin
            // A simultaneous tick stays pending and restarts from IDLE.
            state <= COMMIT;
          end else if (tick) begin
            // Late sample: keep the old pair on the DAC, restart the engine.
            Got_Odd            <= 1'b0;
            Got_Even           <= 1'b0;
            bus.o_Sample_Start <= 1'b1;
            Tick_Pending       <= 1'b0;
            if (bus.o_Underrun_Count != UNDERRUN_MAX) begin
              bus.o_Underrun_Count <= bus.o_Underrun_Count + UNDERRUN_W'(1);
            end
          end
        end

        COMMIT: begin
          bus.o_Data_Odd     <= bus.i_Mute ? '0 : Odd_Hold;
          bus.o_Data_Even    <= bus.i_Mute ? '0 : Even_Hold;
          bus.o_Sample_Ready <= 1'b1;
          state              <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dac_sample_scheduler.sv
// tb/tb_dac_sample_scheduler.sv - self-checking bench for dac_sample_scheduler
module tb_dac_sample_scheduler;
  import dac_sample_scheduler_pkg::*;

  localparam int CT = 16;

  logic clk  = 1'b0;
  logic rst  = 1'b1;
  logic rst2 = 1'b1;

  always #5 clk = ~clk;

  dac_sample_scheduler_if #(.UNDERRUN_W(8)) bus1 ();
  dac_sample_scheduler_if #(.UNDERRUN_W(2)) bus2 ();

  dac_sample_scheduler #(.CLOCK_TICKS(CT), .UNDERRUN_W(8)) dut (
    .i_Clock (clk),
    .i_Reset (rst),
    .bus     (bus1.slave)
  );

  dac_sample_scheduler #(.CLOCK_TICKS(CT), .UNDERRUN_W(2)) dut_sat (
    .i_Clock (clk),
    .i_Reset (rst2),
    .bus     (bus2.slave)
  );

  int tests = 0;
  int fails = 0;
  int e     = 0;   // non-reset edges since reset release (main DUT)
  int e2    = 0;   // same for the saturation DUT
  bit live  = 0;

  // Behavioural model: one sample request per period, pair commit, late-sample accounting
  bit          m_waiting, m_committing, m_pending, m_got_o, m_got_e, m_tick;
  bit          m_start, m_ready;
  logic [31:0] m_hold_o, m_hold_e, m_odd, m_even;
  int          m_count;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, e, act, exp);
    end
  endtask

  always @(posedge clk) begin
    live = 1;
    if (rst) begin
      m_waiting = 0; m_committing = 0; m_pending = 0; m_got_o = 0; m_got_e = 0;
      m_start = 0; m_ready = 0; m_hold_o = '0; m_hold_e = '0;
      m_odd = '0; m_even = '0; m_count = 0; e = 0;
    end else begin
      m_tick  = ((e % CT) == CT - 1);
      m_start = 0;
      m_ready = 0;
      if (m_committing) begin
        m_odd        = bus1.i_Mute ? 32'h0 : m_hold_o;
        m_even       = bus1.i_Mute ? 32'h0 : m_hold_e;
        m_ready      = 1;
        m_committing = 0;
        if (m_tick) m_pending = 1;
      end else if (!m_waiting) begin
        if (m_tick || m_pending) begin
          m_start = 1; m_pending = 0; m_waiting = 1; m_got_o = 0; m_got_e = 0;
        end
      end else begin
        if (bus1.i_Odd_Valid)  begin m_hold_o = bus1.i_Odd_Data;  m_got_o = 1; end
        if (bus1.i_Even_Valid) begin m_hold_e = bus1.i_Even_Data; m_got_e = 1; end
        if (m_got_o && m_got_e) begin
          m_waiting = 0; m_committing = 1;
          if (m_tick) m_pending = 1;
        end else if (m_tick) begin
          m_count = (m_count == 255) ? 255 : m_count + 1;
          m_got_o = 0; m_got_e = 0; m_start = 1;
        end
      end
      e++;
    end
    if (rst2) e2 = 0; else e2++;
  end

  // Every-cycle comparison against the model, plus the saturation DUT's count
  always @(negedge clk) begin
    if (live) begin
      check("sample_start",   32'(bus1.o_Sample_Start),   32'(m_start));
      check("busy",           32'(bus1.o_Busy),           32'(m_waiting));
      check("sample_ready",   32'(bus1.o_Sample_Ready),   32'(m_ready));
      check("data_odd",       32'(bus1.o_Data_Odd),       m_odd);
      check("data_even",      32'(bus1.o_Data_Even),      m_even);
      check("underrun_count", 32'(bus1.o_Underrun_Count), 32'(m_count));
      if (!rst2) begin
        case (e2)
          16: check("sat_count_p0", 32'(bus2.o_Underrun_Count), 32'd0);
          32: check("sat_count_p1", 32'(bus2.o_Underrun_Count), 32'd1);
          48: check("sat_count_p2", 32'(bus2.o_Underrun_Count), 32'd2);
          64: check("sat_count_p3", 32'(bus2.o_Underrun_Count), 32'd3);
          80: check("sat_count_p4", 32'(bus2.o_Underrun_Count), 32'd3);
          96: check("sat_count_p5", 32'(bus2.o_Underrun_Count), 32'd3);
          default: ;
        endcase
      end
    end
  end

  task automatic go_to(int f);
    for (int i = 0; i < 200 && e < f; i++) @(negedge clk);
    if (e != f) begin
      tests++; fails++;
      $display("FAIL go_to: reached cycle %0d, wanted %0d", e, f);
    end
  endtask

  task automatic wait_start(output int at);
    at = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus1.o_Sample_Start === 1'b1) begin
        at = e;
        break;
      end
    end
    if (at < 0) begin
      tests++; fails++;
      $display("FAIL start_timeout: no start within 40 cycles (at %0d), expected one", e);
    end
  endtask

  task automatic drive(bit ov, logic [31:0] od, bit ev, logic [31:0] ed);
    bus1.i_Odd_Valid  = ov; bus1.i_Odd_Data  = od;
    bus1.i_Even_Valid = ev; bus1.i_Even_Data = ed;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    int s;
    bus1.i_Mute = 0; drive(0, '0, 0, '0);
    bus2.i_Mute = 0; bus2.i_Odd_Valid = 0; bus2.i_Odd_Data = '0;
    bus2.i_Even_Valid = 0; bus2.i_Even_Data = '0;
    repeat (3) @(negedge clk);
    rst = 0; rst2 = 0;
    check("reset_data_odd", 32'(bus1.o_Data_Odd), 32'h0);
    check("reset_busy",     32'(bus1.o_Busy), 32'h0);
    check("reset_start",    32'(bus1.o_Sample_Start), 32'h0);
    check("reset_count",    32'(bus1.o_Underrun_Count), 32'h0);

    // Normal pair, odd first
    wait_start(s);
    check("first_start_cycle", 32'(s), 32'd16);
    go_to(19); drive(1, 32'h00001234, 0, '0);
    go_to(20); drive(0, '0, 0, '0);
    go_to(21); drive(0, '0, 1, 32'hFFFF0001);
    go_to(22); drive(0, '0, 0, '0);
    go_to(23);
    check("normal_ready", 32'(bus1.o_Sample_Ready), 32'd1);
    check("normal_odd",   32'(bus1.o_Data_Odd),  32'h00001234);
    check("normal_even",  32'(bus1.o_Data_Even), 32'hFFFF0001);
    check("normal_count", 32'(bus1.o_Underrun_Count), 32'd0);

    // Both strobes in one cycle
    wait_start(s);
    check("second_start_cycle", 32'(s), 32'd32);
    go_to(34); drive(1, 32'h7FFFFFFF, 1, 32'h80000000);
    go_to(35); drive(0, '0, 0, '0);
    go_to(36);
    check("simul_ready", 32'(bus1.o_Sample_Ready), 32'd1);
    check("simul_odd",   32'(bus1.o_Data_Odd),  32'h7FFFFFFF);
    check("simul_even",  32'(bus1.o_Data_Even), 32'h80000000);
    go_to(37);
    check("simul_single_ready", 32'(bus1.o_Sample_Ready), 32'd0);

    // Underrun: odd only, then flags must restart from scratch
    wait_start(s);
    go_to(50); drive(1, 32'h11111111, 0, '0);
    go_to(51); drive(0, '0, 0, '0);
    go_to(64);
    check("underrun_count", 32'(bus1.o_Underrun_Count), 32'd1);
    check("underrun_restart", 32'(bus1.o_Sample_Start), 32'd1);
    check("underrun_hold_odd",  32'(bus1.o_Data_Odd),  32'h7FFFFFFF);
    check("underrun_hold_even", 32'(bus1.o_Data_Even), 32'h80000000);
    go_to(66); drive(0, '0, 1, 32'h33333333);
    go_to(67); drive(0, '0, 0, '0);
    go_to(68);
    check("underrun_no_stale_commit", 32'(bus1.o_Sample_Ready), 32'd0);
    go_to(70); drive(1, 32'h22222222, 0, '0);
    go_to(71); drive(0, '0, 0, '0);
    go_to(72);
    check("recover_ready", 32'(bus1.o_Sample_Ready), 32'd1);
    check("recover_odd",   32'(bus1.o_Data_Odd),  32'h22222222);
    check("recover_even",  32'(bus1.o_Data_Even), 32'h33333333);

    // Stray strobes while idle, then a muted commit
    go_to(75); drive(1, 32'hDEADBEEF, 1, 32'hCAFEF00D);
    go_to(76); drive(0, '0, 0, '0);
    go_to(78);
    check("stray_odd",  32'(bus1.o_Data_Odd),  32'h22222222);
    check("stray_even", 32'(bus1.o_Data_Even), 32'h33333333);
    wait_start(s);
    bus1.i_Mute = 1;
    go_to(81); drive(1, 32'h44444444, 0, '0);
    go_to(82); drive(0, '0, 1, 32'h55555555);
    go_to(83); drive(0, '0, 0, '0);
    go_to(84);
    check("mute_ready", 32'(bus1.o_Sample_Ready), 32'd1);
    check("mute_odd",   32'(bus1.o_Data_Odd),  32'h0);
    check("mute_even",  32'(bus1.o_Data_Even), 32'h0);
    bus1.i_Mute = 0;

    // Reset while waiting with only the odd half captured
    wait_start(s);
    go_to(98); drive(1, 32'h66666666, 0, '0);
    go_to(99); drive(0, '0, 0, '0);
    go_to(100);
    rst = 1;
    repeat (2) @(negedge clk);
    check("midreset_busy", 32'(bus1.o_Busy), 32'h0);
    check("midreset_ready", 32'(bus1.o_Sample_Ready), 32'h0);
    rst = 0;
    wait_start(s);
    check("restart_start_cycle", 32'(s), 32'd16);
    check("restart_odd", 32'(bus1.o_Data_Odd), 32'h0);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
